// File: rtl/seq_detect_param_if.sv
// rtl/seq_detect_param_if.sv - serial detector bus: data/enable, pattern load, counter control and status
interface seq_detect_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             en;
    logic             in;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             cnt_clr;
    logic             out;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
        output en, in, pat_load, pat_in, cnt_clr,
        input  out, match_cnt, cnt_sat
    );

    modport slave (
        input  en, in, pat_load, pat_in, cnt_clr,
        output out, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parameterised serial pattern detector, optional match counter under SEQDET_COUNT_EN
module seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter int               OVERLAP = 1,
    parameter int               CNT_W   = 8
) (
    input logic                clk,
    input logic                reset_n,
    seq_detect_param_if.slave  bus
);
    localparam int             FW       = $clog2(PAT_W);
    localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_W - 1);

    logic [PAT_W-2:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] window;
    logic             match;

    // Candidate window is the stored history plus the bit on the wire this cycle (zero latency).
    always_comb begin
        window = {hist_q, bus.in};
        match  = reset_n & bus.en & ~bus.pat_load & (fill_q == FILL_MAX) & (window == pat_q);
    end

    assign bus.out = match;

    // Next-state: pattern load discards the bit and restarts filling; otherwise shift on consumed bits.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        if (bus.pat_load) begin
            pat_d  = bus.pat_in;
            fill_d = '0;
        end else if (bus.en) begin
            hist_d = window[PAT_W-2:0];
            if (match && (OVERLAP == 0)) begin
                fill_d = '0;
            end else if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // History, fill level and pattern registers; reset outranks every other control.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= PATTERN;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
        end
    end

`ifdef SEQDET_COUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating match counter; a clear in the same cycle as a match wins.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.match_cnt = cnt_q;
    assign bus.cnt_sat   = &cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = bus.cnt_clr;
    assign bus.match_cnt  = '0;
    assign bus.cnt_sat    = 1'b0;
`endif
endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - directed vector bench for seq_detect_param (overlap, non-overlap, 2-bit counter)
module tb_seq_detect_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       en, in_bit, pat_load, cnt_clr;
    logic [3:0] pat_in;

    seq_detect_param_if #(.PAT_W(4), .CNT_W(8)) if_a ();
    seq_detect_param_if #(.PAT_W(4), .CNT_W(8)) if_b ();
    seq_detect_param_if #(.PAT_W(4), .CNT_W(2)) if_c ();

    assign if_a.en = en;  assign if_a.in = in_bit;  assign if_a.pat_load = pat_load;
    assign if_a.pat_in = pat_in;  assign if_a.cnt_clr = cnt_clr;
    assign if_b.en = en;  assign if_b.in = in_bit;  assign if_b.pat_load = pat_load;
    assign if_b.pat_in = pat_in;  assign if_b.cnt_clr = cnt_clr;
    assign if_c.en = en;  assign if_c.in = in_bit;  assign if_c.pat_load = pat_load;
    assign if_c.pat_in = pat_in;  assign if_c.cnt_clr = cnt_clr;

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(8))
        dut_a (.clk(clk), .reset_n(reset_n), .bus(if_a));
    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_W(8))
        dut_b (.clk(clk), .reset_n(reset_n), .bus(if_b));
    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(2))
        dut_c (.clk(clk), .reset_n(reset_n), .bus(if_c));

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       in_bit;
        logic       ld;
        logic [3:0] pat;
        logic       clr;
        logic       exp_a;   // expected out for overlapping instances (a and c)
        logic       exp_b;   // expected out for non-overlapping instance
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cnt_a = 0, cnt_b = 0, cnt_c = 0;

    function automatic int cw(input int c);
`ifdef SEQDET_COUNT_EN
        return c;
`else
        return 0;
`endif
    endfunction

    task automatic push(input logic r, input logic e, input logic i, input logic l,
                        input logic [3:0] p, input logic c, input logic ea, input logic eb);
        vec_t v;
        v.rst_n = r; v.en = e; v.in_bit = i; v.ld = l; v.pat = p; v.clr = c;
        v.exp_a = ea; v.exp_b = eb;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %0d, want %0d", name, idx, got, want);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        reset_n  = v.rst_n;
        en       = v.en;
        in_bit   = v.in_bit;
        pat_load = v.ld;
        pat_in   = v.pat;
        cnt_clr  = v.clr;
        #1;
        check("out_a", idx, int'(if_a.out), int'(v.exp_a));
        check("out_b", idx, int'(if_b.out), int'(v.exp_b));
        check("out_c", idx, int'(if_c.out), int'(v.exp_a));
        check("cnt_a", idx, int'(if_a.match_cnt), cw(cnt_a));
        check("cnt_b", idx, int'(if_b.match_cnt), cw(cnt_b));
        check("cnt_c", idx, int'(if_c.match_cnt), cw(cnt_c));
        check("sat_a", idx, int'(if_a.cnt_sat), cw(cnt_a == 255 ? 1 : 0));
        check("sat_c", idx, int'(if_c.cnt_sat), cw(cnt_c == 3 ? 1 : 0));
        @(posedge clk);
        if (!v.rst_n || v.clr) begin
            cnt_a = 0; cnt_b = 0; cnt_c = 0;
        end else begin
            if (v.exp_a && cnt_a < 255) cnt_a++;
            if (v.exp_a && cnt_c < 3)   cnt_c++;
            if (v.exp_b && cnt_b < 255) cnt_b++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        reset_n = 1'b0; en = 1'b0; in_bit = 1'b0; pat_load = 1'b0; pat_in = 4'b0; cnt_clr = 1'b0;
        repeat (2) @(posedge clk);

        // reset state
        push(0, 0, 0, 0, 4'b0000, 0, 0, 0);
        // 1101101: overlap hits bits 4 and 7, non-overlap only bit 4
        push(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 0, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 1, 0, 4'b0000, 0, 1, 1);
        push(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 0, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 1, 0, 4'b0000, 0, 1, 0);
        // further 101 groups: drive the 2-bit counter into saturation
        push(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 0, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 1, 0, 4'b0000, 0, 1, 1);
        push(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 0, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 1, 0, 4'b0000, 0, 1, 0);
        push(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 0, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 1, 0, 4'b0000, 1, 1, 1);   // clear coincides with a match
        // reset outranks pat_load / en
        push(0, 1, 1, 1, 4'b0110, 0, 0, 0);
        // 110, en gap with in=1, then the final 1
        push(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 0, 0, 4'b0000, 0, 0, 0);
        push(1, 0, 1, 0, 4'b0000, 0, 0, 0);
        push(1, 0, 1, 0, 4'b0000, 0, 0, 0);
        push(1, 0, 1, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 1, 0, 4'b0000, 0, 1, 1);
        // 110, load 0110 (bit discarded), then 0110
        push(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 0, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 1, 1, 4'b0110, 0, 0, 0);
        push(1, 1, 0, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 0, 0, 4'b0000, 0, 1, 1);
        // 110 under pattern 0110, reset mid-sequence restores 1101
        push(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 0, 0, 4'b0000, 0, 1, 0);
        push(0, 1, 0, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 1, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 0, 0, 4'b0000, 0, 0, 0);
        push(1, 1, 1, 0, 4'b0000, 0, 1, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // out forced low while reset is held on a would-be matching bit
        v.pat = 4'b0000; v.ld = 1'b0; v.clr = 1'b0; v.en = 1'b1;
        v.rst_n = 1'b1; v.in_bit = 1'b1; v.exp_a = 1'b0; v.exp_b = 1'b0;
        apply(v, 100);
        v.in_bit = 1'b0;
        apply(v, 101);
        v.rst_n = 1'b0; v.in_bit = 1'b1;
        apply(v, 102);
        v.rst_n = 1'b1; v.en = 1'b0;
        apply(v, 103);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
